// File: rtl/hazard_issue_ctrl_pkg.sv
// Shared types and constants for the WISC ID->EX issue controller.
// Optional feature macro used across this slice: WISC_FWD_EN (EX/MEM forwarding present).
package wisc_ctrl_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    CT_WAIT = 2'd1,
    HALT    = 2'd2
  } state_e;

  // One in-flight register writer: valid, destination, and "is a load".
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_issue_ctrl_if.sv
// ID-stage decode flags in, issue/stall decisions out.
// The master side is the decode stage, the slave side is the issue controller.
interface hazard_issue_ctrl_if;
  import wisc_ctrl_pkg::*;

  logic             mem_stall;
  logic             id_valid;
  logic             id_readEn1;
  logic             id_readEn2;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_regWrite;
  logic [REG_W-1:0] id_rd;
  logic             id_memRead;
  logic             id_branch;
  logic             id_jump;
  logic             id_halt;
  logic             stall_if;
  logic             bubble_ex;
  logic             issue;
  logic             halted;

  modport master (
    output mem_stall, id_valid, id_readEn1, id_readEn2, id_rs, id_rt,
           id_regWrite, id_rd, id_memRead, id_branch, id_jump, id_halt,
    input  stall_if, bubble_ex, issue, halted
  );

  modport slave (
    input  mem_stall, id_valid, id_readEn1, id_readEn2, id_rs, id_rt,
           id_regWrite, id_rd, id_memRead, id_branch, id_jump, id_halt,
    output stall_if, bubble_ex, issue, halted
  );

endinterface

// File: rtl/hazard_issue_ctrl_hazard_cmp.sv
// Compares one scoreboard entry against the ID source registers.
// Under WISC_FWD_EN it also reports whether the matching writer is a load.
module hazard_cmp
  import wisc_ctrl_pkg::*;
(
  input  logic             v,
  input  logic [REG_W-1:0] rd,
`ifdef WISC_FWD_EN
  input  logic             ld,
  output logic             match_ld,
`endif
  input  logic             read_en1,
  input  logic             read_en2,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             match
);

  // R0 is an ordinary register here, so no zero-register exclusion.
  assign match = v & ((read_en1 & (rs == rd)) | (read_en2 & (rt == rd)));

`ifdef WISC_FWD_EN
  assign match_ld = match & ld;
`endif

endmodule

// File: rtl/hazard_issue_ctrl.sv
// Issue controller between ID and EX of the WISC 5-stage pipeline.
// Tracks in-flight writers (EX, MEM) in a shift scoreboard, interlocks on
// RAW hazards, holds fetch for the control-transfer penalty, and parks in
// HALT until reset. WB is not tracked: the register file writes through.
// Optional feature macro: WISC_FWD_EN -- with forwarding only load-use stalls.
module hazard_issue_ctrl
  import wisc_ctrl_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int CT_PENALTY = 2   // legal range 1..7 (3-bit counter)
) (
  input  logic                clk,
  input  logic                rst,
  hazard_issue_ctrl_if.slave  bus
);

  state_e     state_q, state_d;
  logic [2:0] cnt_q,   cnt_d;
  sb_entry_t  sb_q [DEPTH];
  sb_entry_t  sb_d [DEPTH];

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] hit;
  logic             haz;
  logic             issue;
  logic             stall_if;
  logic             bubble_ex;
  logic             halted;

`ifdef WISC_FWD_EN
  logic [DEPTH-1:0] match_ld;
`endif

  // One comparator per tracked pipeline stage.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    hazard_cmp u_cmp (
      .v        (sb_q[g].v),
      .rd       (sb_q[g].rd),
`ifdef WISC_FWD_EN
      .ld       (sb_q[g].ld),
      .match_ld (match_ld[g]),
`endif
      .read_en1 (bus.id_readEn1),
      .read_en2 (bus.id_readEn2),
      .rs       (bus.id_rs),
      .rt       (bus.id_rt),
      .match    (match[g])
    );
  end

  // Select which matches stall: only a load in EX with forwarding, any match without.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit = '0;
`ifdef WISC_FWD_EN
    hit[0] = match_ld[0];
`else
    hit = match;
`endif
    haz = bus.id_valid & (|hit);
  end

  // Output decode from current state, scoreboard and ID inputs.
  always_comb begin
    issue     = 1'b0;
    stall_if  = 1'b1;
    bubble_ex = 1'b1;
    halted    = (state_q == HALT);
    if (state_q == RUN) begin
      issue     = bus.id_valid & ~haz & ~bus.mem_stall;
      stall_if  = haz | bus.mem_stall;
      bubble_ex = ~issue;
    end
  end

  assign bus.issue     = issue;
  assign bus.stall_if  = stall_if;
  assign bus.bubble_ex = bubble_ex;
  assign bus.halted    = halted;

  // Next-state: shift scoreboard, sequence RUN/CT_WAIT/HALT; mem_stall freezes all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < DEPTH; i++) sb_d[i] = sb_q[i];

    if (!bus.mem_stall) begin
      sb_d[0].v  = issue & bus.id_regWrite;
      sb_d[0].rd = issue ? bus.id_rd : '0;
      sb_d[0].ld = issue & bus.id_memRead;
      for (int i = 1; i < DEPTH; i++) sb_d[i] = sb_q[i-1];

      case (state_q)
        RUN: begin
          if (issue && bus.id_halt) begin
            state_d = HALT;
          end else if (issue && (bus.id_branch || bus.id_jump)) begin
            state_d = CT_WAIT;
            cnt_d   = 3'(CT_PENALTY);
          end
        end
        CT_WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  // State registers with synchronous reset; scoreboard is cleared so no stale writer survives.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      // NOTE: the scoreboard must be reset, unlike a data RAM: a stale valid bit would stall forever.
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= sb_d[i];
    end
  end

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Directed self-checking bench for hazard_issue_ctrl (DEPTH=2, CT_PENALTY=2).
// Expected stall counts follow WISC_FWD_EN when the bench is built with it.
module tb_hazard_issue_ctrl;
  import wisc_ctrl_pkg::*;

`ifdef WISC_FWD_EN
  localparam int EXP_DEP   = 0;  // non-load writer forwarded
  localparam int EXP_LDUSE = 1;  // load-use costs one bubble
  localparam int EXP_ST    = 0;  // LBI writer is not a load
`else
  localparam int EXP_DEP   = 2;
  localparam int EXP_LDUSE = 2;
  localparam int EXP_ST    = 2;
`endif

  typedef struct {
    bit       valid;
    bit       re1;
    bit [2:0] rs;
    bit       re2;
    bit [2:0] rt;
    bit       rw;
    bit [2:0] rd;
    bit       ld;
    bit       br;
    bit       jp;
    bit       ht;
  } id_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_issue_ctrl_if bus ();

  hazard_issue_ctrl #(.DEPTH(2), .CT_PENALTY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic id_t ins(input bit re1, input bit [2:0] rs, input bit re2, input bit [2:0] rt,
                              input bit rw, input bit [2:0] rd, input bit ld,
                              input bit br, input bit jp, input bit ht);
    id_t t;
    t.valid = 1'b1; t.re1 = re1; t.rs = rs; t.re2 = re2; t.rt = rt;
    t.rw = rw; t.rd = rd; t.ld = ld; t.br = br; t.jp = jp; t.ht = ht;
    return t;
  endfunction

  function automatic id_t nop();
    id_t t = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t.valid = 1'b0;
    return t;
  endfunction

  task automatic drive(input id_t t);
    bus.id_valid    = t.valid;
    bus.id_readEn1  = t.re1;
    bus.id_rs       = t.rs;
    bus.id_readEn2  = t.re2;
    bus.id_rt       = t.rt;
    bus.id_regWrite = t.rw;
    bus.id_rd       = t.rd;
    bus.id_memRead  = t.ld;
    bus.id_branch   = t.br;
    bus.id_jump     = t.jp;
    bus.id_halt     = t.ht;
  endtask

  // Hold one instruction in ID until it issues; count and check the stall cycles.
  task automatic run_instr(input string tag, input id_t t, input int exp_stalls);
    int stalls = 0;
    bit done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      drive(t);
      #1;
      if (bus.issue === 1'b1) begin
        done = 1'b1;
        check({tag, "_bub_on_issue"}, bus.bubble_ex, 0);
      end else begin
        stalls++;
        check({tag, "_stall_if"}, bus.stall_if, 1);
        check({tag, "_bub"}, bus.bubble_ex, 1);
      end
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_stalls"}, stalls, exp_stalls);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive(nop());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.mem_stall = 1'b0;
    drive(nop());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall_if", bus.stall_if, 0);
    check("rst_bubble",   bus.bubble_ex, 1);
    check("rst_issue",    bus.issue, 0);
    check("rst_halted",   bus.halted, 0);

    // RAW on rs: ADDI r1 then ADD r2,r1,r3.
    run_instr("addi",    ins(1, 2, 0, 0, 1, 1, 0, 0, 0, 0), 0);
    run_instr("add_dep", ins(1, 1, 1, 3, 1, 2, 0, 0, 0, 0), EXP_DEP);
    idle(2);

    // Load-use on rt, then the same pair with readEn2 off.
    run_instr("ld4",       ins(1, 5, 0, 0, 1, 4, 1, 0, 0, 0), 0);
    run_instr("sub_lduse", ins(1, 6, 1, 4, 1, 2, 0, 0, 0, 0), EXP_LDUSE);
    idle(2);
    run_instr("ld4b",      ins(1, 5, 0, 0, 1, 4, 1, 0, 0, 0), 0);
    run_instr("sub_nore2", ins(1, 6, 0, 4, 1, 2, 0, 0, 0, 0), 0);
    idle(2);

    // False dependency through unread fields, then ST reading rt.
    run_instr("wr5", ins(1, 1, 0, 0, 1, 5, 0, 0, 0, 0), 0);
    run_instr("lbi", ins(0, 5, 0, 5, 1, 5, 0, 0, 0, 0), 0);
    run_instr("st",  ins(1, 7, 1, 5, 0, 0, 0, 0, 0, 0), EXP_ST);
    idle(2);

    // R0 treated as a real register.
    run_instr("wr0", ins(1, 1, 0, 0, 1, 0, 0, 0, 0, 0), 0);
    run_instr("rd0", ins(1, 0, 0, 0, 1, 2, 0, 0, 0, 0), EXP_DEP);
    idle(2);

    // Idle RUN: no hazard stall, bubble into EX.
    @(negedge clk); drive(nop()); #1;
    check("idle_stall_if", bus.stall_if, 0);
    check("idle_bubble",   bus.bubble_ex, 1);
    check("idle_issue",    bus.issue, 0);

    // Branch penalty, then JAL whose hazard is absorbed by the wait window.
    run_instr("beqz",     ins(1, 1, 0, 0, 0, 0, 0, 1, 0, 0), 0);
    run_instr("after_br", ins(0, 0, 0, 0, 1, 3, 0, 0, 0, 0), 2);
    idle(2);
    run_instr("jal7",   ins(0, 0, 0, 0, 1, 7, 0, 0, 1, 0), 0);
    run_instr("use_r7", ins(1, 7, 0, 0, 1, 1, 0, 0, 0, 0), 2);
    idle(2);

    // mem_stall for 3 cycles inside CT_WAIT: counter and scoreboard frozen.
    run_instr("jal3", ins(0, 0, 0, 0, 1, 3, 0, 0, 1, 0), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.mem_stall = 1'b1;
      drive(ins(1, 3, 0, 0, 1, 1, 0, 0, 0, 0));
      #1;
      check("ms_ct_stall_if", bus.stall_if, 1);
      check("ms_ct_issue",    bus.issue, 0);
    end
    @(negedge clk);
    bus.mem_stall = 1'b0;
    drive(nop());
    #1;
    check("ms_release_stall_if", bus.stall_if, 1);
    run_instr("use_r3", ins(1, 3, 0, 0, 1, 1, 0, 0, 0, 0), 1);
    idle(2);

    // mem_stall in RUN blocks issue of a hazard-free instruction.
    @(negedge clk);
    bus.mem_stall = 1'b1;
    drive(ins(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    #1;
    check("ms_run_issue",    bus.issue, 0);
    check("ms_run_stall_if", bus.stall_if, 1);
    @(negedge clk);
    bus.mem_stall = 1'b0;
    drive(nop());
    run_instr("ms_run_after", ins(0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 0);
    idle(2);

    // Reset while a hazard is pending discards the in-flight writer.
    run_instr("wr6", ins(0, 0, 0, 0, 1, 6, 0, 0, 0, 0), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(ins(1, 6, 0, 0, 1, 1, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_haz_issue", bus.issue, 1);
    idle(2);

    // Reset inside CT_WAIT returns to RUN immediately.
    run_instr("br_rst", ins(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(nop());
    @(negedge clk);
    rst = 1'b0;
    drive(ins(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    #1;
    check("rst_ct_issue", bus.issue, 1);
    idle(2);

    // HALT with a branch flag also set: HALT wins and is sticky.
    run_instr("halt", ins(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(c[0] ? nop() : ins(0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
      #1;
      check("halt_halted",   bus.halted, 1);
      check("halt_stall_if", bus.stall_if, 1);
      check("halt_issue",    bus.issue, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(nop());
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_halt_halted",   bus.halted, 0);
    check("post_halt_stall_if", bus.stall_if, 0);
    run_instr("post_halt", ins(1, 2, 0, 0, 1, 1, 0, 0, 0, 0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
